// File: rtl/pulse_stream_fifo_adapter.sv
// Buffers single-cycle event pulses in a DEPTH-entry FIFO and presents them as a
// ready/valid stream, with occupancy, drop counting and a selectable overflow policy.
module pulse_stream_fifo_adapter #(
    parameter int TILE_SIZE        = 4,
    parameter int DATA_WIDTH       = 16,
    parameter int DEPTH            = 4,
    parameter int DROP_CNT_W       = 16,
    parameter int OVERWRITE_NEWEST = 0
) (
    input  logic                                   clk,
    input  logic                                   rst_n,
    input  logic                                   pulse_valid,
    input  logic signed [TILE_SIZE*DATA_WIDTH-1:0] pulse_vec,
    output logic                                   out_valid,
    input  logic                                   out_ready,
    output logic signed [TILE_SIZE*DATA_WIDTH-1:0] out_vec,
    output logic [$clog2(DEPTH+1)-1:0]             level,
    output logic                                   full,
    output logic [DROP_CNT_W-1:0]                  drop_cnt,
    output logic                                   overflow,
    input  logic                                   clr_stats
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = $clog2(DEPTH+1);
    localparam int VW = TILE_SIZE*DATA_WIDTH;

    logic [VW-1:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          fire;
    logic          push;
    logic          ovf_event;

    // Stream handshake: a beat transfers on any rising edge where out_valid && out_ready;
    // out_valid never drops and out_vec never changes until that beat has transferred.
    assign out_valid = (level != '0);
    assign full      = (level == LW'(DEPTH));
    assign out_vec   = mem[rd_ptr];
    assign fire      = out_valid && out_ready;
    assign push      = pulse_valid && (!full || fire);
    assign ovf_event = pulse_valid && full && !fire;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= pulse_vec;
                wr_ptr      <= wr_ptr + AW'(1);
            end else if (ovf_event && (OVERWRITE_NEWEST != 0)) begin
                // Newest entry is never the head while full because DEPTH >= 2.
                mem[wr_ptr - AW'(1)] <= pulse_vec;
            end
            if (fire) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push, fire})
                2'b10:   level <= level + LW'(1);
                2'b01:   level <= level - LW'(1);
                default: level <= level;
            endcase
        end
    end

    // A clear coinciding with an overflow still records that overflow.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            drop_cnt <= '0;
            overflow <= 1'b0;
        end else if (clr_stats) begin
            drop_cnt <= ovf_event ? DROP_CNT_W'(1) : '0;
            overflow <= ovf_event;
        end else if (ovf_event) begin
            if (drop_cnt != '1) begin
                drop_cnt <= drop_cnt + DROP_CNT_W'(1);
            end
            overflow <= 1'b1;
        end
    end

endmodule

// File: tb/tb_pulse_stream_fifo_adapter.sv
// Self-checking bench: drop-newest and overwrite-newest instances share stimulus,
// each checked every cycle against a queue-based model of the adapter.
module tb_pulse_stream_fifo_adapter;

    localparam int DEPTH = 4;
    localparam int VW    = 64;
    localparam int W0    = 3;
    localparam int W1    = 16;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic pulse_valid = 1'b0;
    logic signed [VW-1:0] pulse_vec = '0;
    logic out_ready = 1'b0;
    logic clr_stats = 1'b0;

    logic                 out_valid0, out_valid1;
    logic signed [VW-1:0] out_vec0, out_vec1;
    logic [2:0]           level0, level1;
    logic                 full0, full1;
    logic [W0-1:0]        drop_cnt0;
    logic [W1-1:0]        drop_cnt1;
    logic                 overflow0, overflow1;

    int n_total = 0;
    int n_pass  = 0;

    // Behavioural model state: one queue of pending beats per instance.
    logic [VW-1:0] exp_q0[$];
    logic [VW-1:0] exp_q1[$];
    int            m_cnt0 = 0, m_cnt1 = 0;
    logic          m_ovf0 = 1'b0, m_ovf1 = 1'b0;

    logic [VW-1:0] seq0 [4];
    logic [VW-1:0] seq1 [4];

    always #5 clk = ~clk;

    pulse_stream_fifo_adapter #(
        .TILE_SIZE(4), .DATA_WIDTH(16), .DEPTH(DEPTH), .DROP_CNT_W(W0), .OVERWRITE_NEWEST(0)
    ) dut0 (
        .clk(clk), .rst_n(rst_n), .pulse_valid(pulse_valid), .pulse_vec(pulse_vec),
        .out_valid(out_valid0), .out_ready(out_ready), .out_vec(out_vec0), .level(level0),
        .full(full0), .drop_cnt(drop_cnt0), .overflow(overflow0), .clr_stats(clr_stats)
    );

    pulse_stream_fifo_adapter #(
        .TILE_SIZE(4), .DATA_WIDTH(16), .DEPTH(DEPTH), .DROP_CNT_W(W1), .OVERWRITE_NEWEST(1)
    ) dut1 (
        .clk(clk), .rst_n(rst_n), .pulse_valid(pulse_valid), .pulse_vec(pulse_vec),
        .out_valid(out_valid1), .out_ready(out_ready), .out_vec(out_vec1), .level(level1),
        .full(full1), .drop_cnt(drop_cnt1), .overflow(overflow1), .clr_stats(clr_stats)
    );

    function automatic logic [VW-1:0] pk(input int a, input int b, input int c, input int d);
        return {d[15:0], c[15:0], b[15:0], a[15:0]};
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    endtask

    task automatic cyc();
        @(negedge clk);
        #1;
    endtask

    // Reference model: pops on an accepted beat, appends accepted pulses, and on overflow
    // either discards the pulse or replaces the newest queued beat.
    initial begin
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                exp_q0.delete(); exp_q1.delete();
                m_cnt0 = 0; m_cnt1 = 0; m_ovf0 = 1'b0; m_ovf1 = 1'b0;
            end else begin
                automatic bit f0 = (exp_q0.size() != 0) && out_ready;
                automatic bit f1 = (exp_q1.size() != 0) && out_ready;
                automatic bit o0 = pulse_valid && (exp_q0.size() == DEPTH) && !f0;
                automatic bit o1 = pulse_valid && (exp_q1.size() == DEPTH) && !f1;
                if (f0) void'(exp_q0.pop_front());
                if (f1) void'(exp_q1.pop_front());
                if (pulse_valid && !o0) exp_q0.push_back(pulse_vec);
                if (pulse_valid && !o1) exp_q1.push_back(pulse_vec);
                else if (o1) exp_q1[exp_q1.size()-1] = pulse_vec;
                if (clr_stats) begin
                    m_cnt0 = o0 ? 1 : 0; m_ovf0 = o0;
                    m_cnt1 = o1 ? 1 : 0; m_ovf1 = o1;
                end else begin
                    if (o0) begin m_cnt0 = (m_cnt0 < (1 << W0) - 1) ? m_cnt0 + 1 : m_cnt0; m_ovf0 = 1'b1; end
                    if (o1) begin m_cnt1 = (m_cnt1 < (1 << W1) - 1) ? m_cnt1 + 1 : m_cnt1; m_ovf1 = 1'b1; end
                end
            end
        end
    end

    // Per-cycle comparison of both instances against the model.
    initial begin
        forever begin
            @(negedge clk);
            check("dut0_out_valid", 64'(out_valid0), 64'(exp_q0.size() != 0));
            check("dut1_out_valid", 64'(out_valid1), 64'(exp_q1.size() != 0));
            check("dut0_level", 64'(level0), 64'(exp_q0.size()));
            check("dut1_level", 64'(level1), 64'(exp_q1.size()));
            check("dut0_full", 64'(full0), 64'(exp_q0.size() == DEPTH));
            check("dut1_full", 64'(full1), 64'(exp_q1.size() == DEPTH));
            check("dut0_drop_cnt", 64'(drop_cnt0), 64'(m_cnt0));
            check("dut1_drop_cnt", 64'(drop_cnt1), 64'(m_cnt1));
            check("dut0_overflow", 64'(overflow0), 64'(m_ovf0));
            check("dut1_overflow", 64'(overflow1), 64'(m_ovf1));
            if (exp_q0.size() != 0) check("dut0_out_vec", out_vec0, exp_q0[0]);
            if (exp_q1.size() != 0) check("dut1_out_vec", out_vec1, exp_q1[0]);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        repeat (3) @(negedge clk);
        check("rst_out_valid", 64'({out_valid0, out_valid1}), 64'(0));
        check("rst_level", 64'({level0, level1}), 64'(0));
        check("rst_stats", 64'({drop_cnt0, drop_cnt1, overflow0, overflow1, full0, full1}), 64'(0));
        check("rst_out_vec", out_vec0 | out_vec1, 64'(0));
        #1 rst_n = 1'b1;
        cyc();

        // Single pulse with downstream ready
        pulse_valid = 1'b1; pulse_vec = pk(1, -2, 3, -4); out_ready = 1'b1;
        @(negedge clk);
        check("single_valid", 64'(out_valid0), 64'(1));
        check("single_vec", out_vec0, 64'h fffc_0003_fffe_0001);
        check("single_level1", 64'(level0), 64'(1));
        #1 pulse_valid = 1'b0;
        @(negedge clk);
        check("single_valid_gone", 64'(out_valid0), 64'(0));
        check("single_level0", 64'(level0), 64'(0));
        #1 out_ready = 1'b0;

        // Six pulses A..F into a stalled FIFO
        for (int i = 0; i < 6; i++) begin
            pulse_valid = 1'b1; pulse_vec = pk(16'ha0 + i, 16'hb0 + i, 16'hc0 + i, 16'hd0 + i);
            cyc();
        end
        pulse_valid = 1'b0;
        @(negedge clk);
        check("burst_level", 64'({level0, level1}), {58'd0, 3'd4, 3'd4});
        check("burst_full", 64'({full0, full1}), 64'(2'b11));
        check("burst_drop0", 64'(drop_cnt0), 64'(2));
        check("burst_drop1", 64'(drop_cnt1), 64'(2));
        check("burst_overflow", 64'({overflow0, overflow1}), 64'(2'b11));
        for (int i = 0; i < 4; i++) begin
            seq0[i] = pk(16'ha0 + i, 16'hb0 + i, 16'hc0 + i, 16'hd0 + i);
            seq1[i] = (i == 3) ? pk(16'ha5, 16'hb5, 16'hc5, 16'hd5) : seq0[i];
        end
        for (int i = 0; i < 4; i++) begin
            check("drain_order0", out_vec0, seq0[i]);
            check("drain_order1", out_vec1, seq1[i]);
            #1 out_ready = 1'b1;
            @(negedge clk);
        end
        check("drain_empty", 64'({out_valid0, out_valid1}), 64'(0));
        #1 out_ready = 1'b0;

        // Full FIFO with simultaneous pulse and pop, then wrap
        for (int i = 0; i < 4; i++) begin
            pulse_valid = 1'b1; pulse_vec = {$urandom, $urandom};
            cyc();
        end
        pulse_vec = pk(16'h6, 16'h66, 16'h666, 16'h6666); out_ready = 1'b1;
        @(negedge clk);
        check("g_level", 64'({level0, level1}), {58'd0, 3'd4, 3'd4});
        check("g_drop", 64'({13'd0, drop_cnt0, drop_cnt1}), {45'd0, 3'd2, 16'd2});
        #1;
        for (int i = 0; i < 10; i++) begin
            pulse_vec = {$urandom, $urandom};
            cyc();
        end
        pulse_valid = 1'b0;
        repeat (5) cyc();

        // Saturation and clear priority
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            pulse_valid = 1'b1; pulse_vec = {$urandom, $urandom};
            cyc();
        end
        pulse_valid = 1'b0; clr_stats = 1'b1;
        cyc();
        clr_stats = 1'b0;
        for (int i = 0; i < 9; i++) begin
            pulse_valid = 1'b1; pulse_vec = {$urandom, $urandom};
            cyc();
        end
        pulse_valid = 1'b0;
        @(negedge clk);
        check("sat_drop0", 64'(drop_cnt0), 64'(7));
        check("sat_drop1", 64'(drop_cnt1), 64'(9));
        #1 pulse_valid = 1'b1; clr_stats = 1'b1;
        @(negedge clk);
        check("clr_ovf_drop", 64'({13'd0, drop_cnt0, drop_cnt1}), {45'd0, 3'd1, 16'd1});
        check("clr_ovf_flag", 64'({overflow0, overflow1}), 64'(2'b11));
        #1 pulse_valid = 1'b0;
        @(negedge clk);
        check("clr_only_drop", 64'({drop_cnt0, drop_cnt1}), 64'(0));
        check("clr_only_flag", 64'({overflow0, overflow1}), 64'(0));
        #1 clr_stats = 1'b0; out_ready = 1'b1;
        repeat (5) cyc();

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            pulse_valid = ($urandom_range(0, 99) < 60);
            out_ready   = ($urandom_range(0, 99) < 50);
            clr_stats   = ($urandom_range(0, 99) < 3);
            pulse_vec   = {$urandom, $urandom};
            cyc();
        end
        pulse_valid = 1'b0; clr_stats = 1'b0; out_ready = 1'b1;
        repeat (6) cyc();

        // Reset asserted mid-stream with three entries held
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            pulse_valid = 1'b1; pulse_vec = {$urandom, $urandom};
            cyc();
        end
        pulse_valid = 1'b0;
        @(negedge clk);
        check("pre_rst_level", 64'(level0), 64'(3));
        #3 rst_n = 1'b0;
        #1;
        check("async_rst_valid", 64'({out_valid0, out_valid1}), 64'(0));
        check("async_rst_level", 64'({level0, level1, full0, full1}), 64'(0));
        check("async_rst_stats", 64'({drop_cnt0, drop_cnt1, overflow0, overflow1}), 64'(0));
        check("async_rst_vec", out_vec0 | out_vec1, 64'(0));
        @(negedge clk);
        #1 rst_n = 1'b1;
        cyc();
        pulse_valid = 1'b1; pulse_vec = pk(7, -7, 8, -8);
        @(negedge clk);
        check("post_rst_valid", 64'(out_valid1), 64'(1));
        check("post_rst_vec", out_vec1, 64'h fff8_0008_fff9_0007);
        #1 pulse_valid = 1'b0; out_ready = 1'b1;
        repeat (3) cyc();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
